alu_issue_stage: RTL

- Execute-issue stage directly upstream of the ALU.
- Accepts decoded RV64I integer instructions (OP / OP-IMM), translates opcode/funct3/funct7 into the ALU's 6-bit operation code, and selects operand B (rs2 value or immediate).
- Registers the result into a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU input is always driven from flops.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_op_decode.sv | 46 ++++
 rtl/alu_issue_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation encodings, RV opcode constants and set_less codes shared by the issue stage and decoder.
package alu_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [5:0] ALU_ADD = 6'b00_0000;
    localparam logic [5:0] ALU_SUB = 6'b00_0001;
    localparam logic [5:0] ALU_AND = 6'b10_0000;
    localparam logic [5:0] ALU_OR  = 6'b10_0001;
    localparam logic [5:0] ALU_XOR = 6'b10_0011;
    localparam logic [5:0] ALU_SRA = 6'b11_0000;
    localparam logic [5:0] ALU_SRL = 6'b11_0010;
    localparam logic [5:0] ALU_SLL = 6'b11_0011;
    localparam logic [1:0] SL_NONE     = 2'b00;
    localparam logic [1:0] SL_SIGNED   = 2'b01;
    localparam logic [1:0] SL_UNSIGNED = 2'b10;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_SHAMT} bsel_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode/funct3/funct7 to ALU operation, operand-B select, set_less and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [5:0] operation,
    output bsel_e      b_sel,
    output logic [1:0] set_less,
    output logic       illegal
);
    logic is_op;
    logic alt;
    always_comb begin
        is_op = opcode == OPC_OP;
        // immediate shifts keep shamt[5] in funct7[0], so only [6:1] carries the arithmetic bit
        alt = is_op ? funct7[5] : (funct7[6:1] == 6'b010000);
        illegal = !(opcode == OPC_OP_IMM || (is_op && (funct7 == 7'b000_0000 || funct7 == 7'b010_0000)));
        operation = ALU_ADD;
        set_less = SL_NONE;
        b_sel = is_op ? B_RS2 : B_IMM;
        case (funct3)
            3'b000: operation = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001: operation = ALU_SLL;
            3'b010: begin
                operation = ALU_SUB;
                set_less = SL_SIGNED;
            end
            3'b011: begin
                operation = ALU_SUB;
                set_less = SL_UNSIGNED;
            end
            3'b100: operation = ALU_XOR;
            3'b101: operation = alt ? ALU_SRA : ALU_SRL;
            3'b110: operation = ALU_OR;
            3'b111: operation = ALU_AND;
        endcase
        if (!is_op && (funct3 == 3'b001 || funct3 == 3'b101))
            b_sel = B_SHAMT;
        if (illegal) begin
            operation = ALU_ADD;
            set_less = SL_NONE;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes OP/OP-IMM packets into ALU operations behind a 2-entry skid buffer.
// Define ALU_ISSUE_ILLEGAL_EN to expose out_illegal; otherwise illegal packets issue as a zero-operand add.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int REGADDR  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic [WORDSIZE-1:0] in_rs1_val,
    input  logic [WORDSIZE-1:0] in_rs2_val,
    input  logic [WORDSIZE-1:0] in_imm,
    input  logic [REGADDR-1:0]  in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5:0]          out_operation,
    output logic [WORDSIZE-1:0] out_input_a,
    output logic [WORDSIZE-1:0] out_input_b,
    output logic [1:0]          out_set_less,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic                out_illegal,
`endif
    output logic [REGADDR-1:0]  out_rd
);
    localparam int PW = 6 + 2 * WORDSIZE + 2 + REGADDR;
    logic [5:0]          dec_op;
    bsel_e               dec_bsel;
    logic [1:0]          dec_sl;
    logic                dec_ill;
    logic [WORDSIZE-1:0] a_val;
    logic [WORDSIZE-1:0] b_val;
    logic [PW-1:0]       in_pkt;
    logic [PW-1:0]       main_pkt;
    logic [PW-1:0]       skid_pkt;
    logic                main_v;
    logic                skid_v;
    logic                rdy;
    logic                accept;
    logic                pop;

    alu_op_decode u_decode (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .operation(dec_op),
        .b_sel    (dec_bsel),
        .set_less (dec_sl),
        .illegal  (dec_ill)
    );

    always_comb begin
        a_val = dec_ill ? '0 : in_rs1_val;
        b_val = dec_ill ? '0 :
                (dec_bsel == B_RS2) ? in_rs2_val :
                (dec_bsel == B_IMM) ? in_imm : {{(WORDSIZE-6){1'b0}}, in_imm[5:0]};
        in_pkt = {dec_op, a_val, b_val, dec_sl, in_rd};
        accept = in_valid && rdy && !flush;
        pop = main_v && out_ready;
    end

    // skid_v can only be set while main is full, so refilling main always drains the skid first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy <= 1'b0;
            main_pkt <= '0;
            skid_pkt <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy <= 1'b1;
        end else if (!main_v || pop) begin
            main_v <= skid_v || accept;
            main_pkt <= skid_v ? skid_pkt : accept ? in_pkt : main_pkt;
            skid_v <= 1'b0;
            rdy <= 1'b1;
        end else if (accept) begin
            skid_pkt <= in_pkt;
            skid_v <= 1'b1;
            rdy <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic main_ill;
    logic skid_ill;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ill <= 1'b0;
            skid_ill <= 1'b0;
        end else if (!flush && (!main_v || pop)) begin
            main_ill <= skid_v ? skid_ill : accept ? dec_ill : main_ill;
        end else if (!flush && accept) begin
            skid_ill <= dec_ill;
        end
    end
    assign out_illegal = main_ill;
`endif

    assign {out_operation, out_input_a, out_input_b, out_set_less, out_rd} = main_pkt;
    assign out_valid = main_v;
    assign in_ready = rdy;
endmodule
